fifo_pack_c: RTL and testbench

FIFO_PACK_C -- requirements
Module: fifo_pack_c

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/timeout_cnt.sv | 32 +++
 rtl/fifo_pack_c.sv | 138 +++++++++++++
 tb/tb_fifo_pack_c.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared state encoding and lane-keep helper for the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } pack_state_e;

    // Keep bit for one lane: lanes below the fill count are valid, which
    // yields the thermometer mask (1<<count)-1 when applied across all lanes.
    function automatic logic keep_mask(input int count, input int lane);
        return (lane < count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_cnt
//  Description : Saturating 8-bit idle timer with terminal-count flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] c_TERM = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= 8'd0;
        end else if (enable && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign tc = (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/fifo_pack_c.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pack_c
//  Description : Packs RATIO narrow upstream-FIFO words into one wide word.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_pack_c
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_empty,
    input  logic [IN_WIDTH-1:0]       in_data,
    output logic                      in_rd_en,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep
);

    localparam int                 c_LANE_W = $clog2(RATIO);
    localparam int                 c_CNT_W  = c_LANE_W + 1;
    localparam int                 c_OUT_W  = IN_WIDTH * RATIO;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(RATIO);

    pack_state_e          r_state;
    pack_state_e          w_state_nxt;
    logic [c_OUT_W-1:0]   r_data;
    logic [c_CNT_W-1:0]   r_count;
    logic [RATIO-1:0]     w_keep;
    logic                 w_avail;
    logic                 w_rd_en;
    logic                 w_load_first;
    logic                 w_load_next;
    logic                 w_clear;
    logic                 w_tc;

    timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  ((r_state != ST_FILL) || w_load_next),
        .enable (r_state == ST_FILL),
        .tc     (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pop decision depends only on state, in_empty and out_ready so the
    // upstream FIFO never sees a path from in_data or flush.
    always_comb begin
        w_avail      = !in_empty && !rst;
        w_rd_en      = 1'b0;
        w_load_first = 1'b0;
        w_load_next  = 1'b0;
        w_clear      = 1'b0;
        w_state_nxt  = r_state;
        case (r_state)
            ST_IDLE: begin
                w_rd_en = w_avail;
                if (w_avail) begin
                    w_load_first = 1'b1;
                    w_state_nxt  = (RATIO == 1) ? ST_SEND : ST_FILL;
                end
            end
            ST_FILL: begin
                w_rd_en     = w_avail;
                w_load_next = w_avail;
                if ((w_avail && ((r_count + c_CNT_W'(1)) == c_FULL)) ||
                    flush || (!w_avail && w_tc)) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    w_rd_en = w_avail;
                    if (w_avail) begin
                        w_load_first = 1'b1;
                        w_state_nxt  = ST_FILL;
                    end else begin
                        w_clear     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Starting a new word zero-fills the upper lanes so unfilled lanes read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (w_load_first) begin
            r_data  <= c_OUT_W'(in_data);
            r_count <= c_CNT_W'(1);
        end else if (w_load_next) begin
            for (int i = 0; i < RATIO; i++) begin
                if (r_count == c_CNT_W'(i)) begin
                    r_data[i*IN_WIDTH +: IN_WIDTH] <= in_data;
                end
            end
            r_count <= r_count + c_CNT_W'(1);
        end else if (w_clear) begin
            r_data  <= '0;
            r_count <= '0;
        end
    end

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_keep[i] = keep_mask(int'(r_count), i);
        end
    end

    assign in_rd_en  = w_rd_en;
    assign out_valid = (r_state == ST_SEND);
    assign out_data  = r_data;
    assign out_keep  = w_keep;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_c.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_pack_c
//  Description : Self-checking bench for fifo_pack_c against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pack_c;

    localparam int c_IN_W    = 32;
    localparam int c_RATIO   = 4;
    localparam int c_TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_empty;
    logic [31:0]  in_data;
    logic         in_rd_en;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_keep;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: words being packed, plus the word offered downstream.
    logic [31:0]  mq[$];
    bit           m_hv = 1'b0;
    logic [127:0] m_hdata = '0;
    logic [3:0]   m_hkeep = '0;
    int           m_idle = 0;

    logic [127:0] got_data[$];
    logic [3:0]   got_keep[$];

    fifo_pack_c #(
        .IN_WIDTH (c_IN_W),
        .RATIO    (c_RATIO),
        .TIMEOUT  (c_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .in_rd_en  (in_rd_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, advance the model, cross the edge.
    task automatic tick();
        logic         exp_rd;
        bit           acc;
        bit           in_fill;
        bit           emit;
        logic [127:0] packed_w;
        @(negedge clk);
        exp_rd = !rst && !in_empty && (!m_hv || out_ready);
        check("in_rd_en", in_rd_en, exp_rd);
        check("out_valid", out_valid, m_hv);
        if (m_hv) begin
            check("out_data", out_data, m_hdata);
            check("out_keep", out_keep, m_hkeep);
        end
        if (!rst && out_valid === 1'b1 && out_ready) begin
            got_data.push_back(out_data);
            got_keep.push_back(out_keep);
        end
        if (rst) begin
            mq.delete();
            m_hv   = 1'b0;
            m_idle = 0;
        end else begin
            acc     = exp_rd;
            in_fill = !m_hv && (mq.size() > 0);
            if (m_hv && out_ready) m_hv = 1'b0;
            if (acc) mq.push_back(in_data);
            emit = 1'b0;
            if (mq.size() == c_RATIO) begin
                emit = 1'b1;
            end else if (in_fill && flush) begin
                emit = 1'b1;
            end else if (in_fill && !acc) begin
                m_idle++;
                if (m_idle == c_TIMEOUT) emit = 1'b1;
            end
            if (acc) m_idle = 0;
            if (emit) begin
                packed_w = '0;
                foreach (mq[i]) packed_w |= 128'(mq[i]) << (c_IN_W * i);
                m_hdata = packed_w;
                m_hkeep = 4'((1 << mq.size()) - 1);
                m_hv    = 1'b1;
                mq.delete();
                m_idle  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_empty = 1'b0;
        in_data  = w;
        tick();
    endtask

    task automatic idle(input int n);
        in_empty = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = $urandom;
            tick();
        end
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        in_empty  = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("reset_out_data", out_data, 128'd0);
        check("reset_out_keep", out_keep, 128'd0);
        rst = 1'b0;
        idle(2);

        // Full word with immediate acceptance.
        base = got_data.size();
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        idle(2);
        check("full_count", 128'(got_data.size() - base), 128'd1);
        if (got_data.size() > base) begin
            check("full_data", got_data[base], 128'h00000044_00000033_00000022_00000011);
            check("full_keep", got_keep[base], 128'hF);
        end

        // Two words then a stall: timeout emits the partial word.
        base = got_data.size();
        push(32'hA1); push(32'hA2);
        idle(20);
        check("timeout_count", 128'(got_data.size() - base), 128'd1);
        if (got_data.size() > base) begin
            check("timeout_data", got_data[base], 128'h000000A2_000000A1);
            check("timeout_keep", got_keep[base], 128'h3);
        end

        // Three words and a flush; then a flush while idle does nothing.
        base = got_data.size();
        push(32'hB1); push(32'hB2); push(32'hB3);
        in_empty = 1'b1;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        idle(3);
        check("flush_count", 128'(got_data.size() - base), 128'd1);
        if (got_data.size() > base) begin
            check("flush_data", got_data[base], 128'h000000B3_000000B2_000000B1);
            check("flush_keep", got_keep[base], 128'h7);
        end
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(20);
        check("idle_flush_count", 128'(got_data.size() - base), 128'd1);

        // Backpressure in SEND, then release with a word waiting.
        base      = got_data.size();
        out_ready = 1'b0;
        push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
        in_empty = 1'b0;
        in_data  = 32'h55;
        repeat (10) tick();
        out_ready = 1'b1;
        tick();
        idle(20);
        check("stall_count", 128'(got_data.size() - base), 128'd2);
        if (got_data.size() > base + 1) begin
            check("stall_data", got_data[base], 128'h000000C4_000000C3_000000C2_000000C1);
            check("stall_next_data", got_data[base+1], 128'h00000055);
            check("stall_next_keep", got_keep[base+1], 128'h1);
        end

        // Continuous stream of 16 words.
        base = got_data.size();
        for (int i = 0; i < 16; i++) push($urandom);
        idle(2);
        check("stream_count", 128'(got_data.size() - base), 128'd4);

        // Reset mid-fill discards the partial word.
        base = got_data.size();
        push(32'hD1); push(32'hD2); push(32'hD3);
        in_empty = 1'b1;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 128'd0);
        check("midrst_data", out_data, 128'd0);
        check("midrst_keep", out_keep, 128'd0);
        check("midrst_rd_en", in_rd_en, 128'd0);
        push(32'hE1); push(32'hE2); push(32'hE3); push(32'hE4);
        idle(2);
        check("midrst_count", 128'(got_data.size() - base), 128'd1);
        if (got_data.size() > base) begin
            check("midrst_restart", got_data[base], 128'h000000E4_000000E3_000000E2_000000E1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_empty  = ($urandom_range(0, 3) == 0);
            in_data   = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
